fifo_rd_stream: RTL and testbench

Read-side adapter for the team's sync_fifo. It drains the FIFO through its rd_en/empty/dout port, absorbing the FIFO's one-cycle read latency, and presents the words as a valid/ready stream to downstream logic. A 3-entry output buffer with credit tracking sustains one word per cycle and keeps any combinational path from m_ready to fifo_rd_en out of the design.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_rd_obuf.sv | 64 ++++++
 rtl/fifo_rd_stream.sv | 68 ++++++
 tb/tb_fifo_rd_stream.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and pointer helper for the sync_fifo read-side stream adapter.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH      = 8;
    localparam int OBUF_DEPTH           = 3;
    localparam int SYNC_FIFO_RD_LATENCY = 1;
    localparam int PTR_WIDTH            = 2;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    // Circular-buffer pointer increment, wrapping after the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(OBUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/fifo_rd_obuf.sv
// Three-entry circular register buffer: push at tail, pop at head, occupancy count.
// Holds no flow-control knowledge; the caller guarantees no overflow/underflow.
module fifo_rd_obuf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output ptr_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t occ_q, occ_d;
    logic wr_en;

    assign wr_en = push && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[tail_q] <= push_data;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clr) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            occ_d = occ_q + ptr_t'(push) - ptr_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a sync_fifo (1-cycle read latency) into a valid/ready stream. Read requests
// are issued on credit (buffered + in-flight < 3) so m_ready never reaches fifo_rd_en.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic                  idle
);
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    ptr_t                 occ;
    logic [2:0]           outstanding;
    logic                 drop;
    logic                 capture;
    logic                 pop;

    assign outstanding = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd_en  = rst_n && !fifo_empty && !flush && (outstanding < 3'(OBUF_DEPTH));

    // A word landing on a flush edge belongs to the discarded stream.
    assign drop    = flush && inflight_q;
    assign capture = inflight_q && !drop;
    assign pop     = m_valid && m_ready && !flush;

    always_comb begin
        inflight_d = fifo_rd_en;
        cnt_d      = cnt_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    fifo_rd_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    assign m_valid  = (occ != '0);
    assign xfer_cnt = cnt_q;
    assign idle     = !m_valid && !inflight_q && fifo_empty;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based sync_fifo model feeds the DUT and a
// fetched-word scoreboard predicts rd_en, valid timing, data order and counters.
module tb_fifo_rd_stream;
    logic       clk = 1'b0;
    logic       rst_n, fifo_empty, flush, m_ready;
    logic [7:0] fifo_dout;

    logic        fifo_rd_en, m_valid, idle;
    logic [7:0]  m_data;
    logic [15:0] xfer_cnt;
    logic        rd_en4, m_valid4, idle4;
    logic [7:0]  m_data4;
    logic [3:0]  xfer_cnt4;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .xfer_cnt(xfer_cnt), .idle(idle)
    );

    // Identical instance with a 4-bit counter, for the wrap check.
    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_en4), .flush(flush), .m_valid(m_valid4), .m_data(m_data4),
        .m_ready(m_ready), .xfer_cnt(xfer_cnt4), .idle(idle4)
    );

    typedef struct {
        logic [7:0] data;
        int         ready_at;
    } ent_t;

    ent_t       exp_q[$];   // words taken from the FIFO, not yet delivered
    logic [7:0] fifo_q[$];  // sync_fifo contents
    int  edges, beats, pass_cnt, total_cnt, rd_pulses;
    bit  chk_en, last_reset, beat_seen, saw13;
    logic [7:0] last_beat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        assert (act === req) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, act, req);
    endtask

    task automatic cycle();
        bit exp_rd, exp_v, rd_s, beat_s;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        if (chk_en) begin
            exp_v  = (exp_q.size() > 0) && (edges >= exp_q[0].ready_at);
            exp_rd = rst_n && !fifo_empty && !flush && (exp_q.size() < 3);
            chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
            chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
            if (exp_v) chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0].data});
            if (last_reset) chk("rst_m_data", {24'd0, m_data}, 32'd0);
            chk("idle", {31'd0, idle}, {31'd0, (exp_q.size() == 0) && fifo_empty});
            chk("xfer_cnt", {16'd0, xfer_cnt}, beats & 32'hFFFF);
            chk("xfer_cnt4", {28'd0, xfer_cnt4}, beats & 32'hF);
        end
        rd_s   = fifo_rd_en;
        beat_s = m_valid && m_ready && rst_n && !flush;
        if (rd_s) rd_pulses++;
        if (beat_s) begin
            last_beat = m_data;
            beat_seen = 1'b1;
            if (m_data == 8'h13) saw13 = 1'b1;
        end
        @(posedge clk);
        #1;
        edges++;
        last_reset = !rst_n;
        if (!rst_n) begin
            exp_q.delete();
            fifo_q.delete();
            beats = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (beat_s) begin
                if (exp_q.size() > 0) exp_q.delete(0);
                beats++;
            end
            if (rd_s && fifo_q.size() > 0) begin
                fifo_dout = fifo_q.pop_front();
                exp_q.push_back('{fifo_dout, edges + 1});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        int pushed;
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b1; fifo_dout = 8'h00; fifo_empty = 1'b0;
        edges = 0; beats = 0; pass_cnt = 0; total_cnt = 0; rd_pulses = 0;
        chk_en = 1'b0; last_reset = 1'b0; beat_seen = 1'b0; saw13 = 1'b0; last_beat = 8'h00;

        // Reset held with a non-empty FIFO
        fifo_q.push_back(8'hAA);
        cycle();
        chk_en = 1'b1;
        repeat (2) begin
            fifo_q.push_back(8'hAA);
            cycle();
        end
        rst_n = 1'b1;

        // Full-rate drain of 16 words
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        rd_pulses = 0;
        repeat (22) cycle();
        chk("t2_rd_pulses", rd_pulses, 32'd16);
        chk("t2_xfer_cnt", {16'd0, xfer_cnt}, 32'd16);
        chk("t2_idle", {31'd0, idle}, 32'd1);

        // Back-pressure: only three reads, head word held
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        m_ready = 1'b0;
        rd_pulses = 0;
        repeat (8) cycle();
        chk("t3_rd_pulses", rd_pulses, 32'd3);
        chk("t3_hold_valid", {31'd0, m_valid}, 32'd1);
        chk("t3_hold_data", {24'd0, m_data}, 32'd0);
        m_ready = 1'b1;
        repeat (22) cycle();
        chk("t3_xfer_cnt", {16'd0, xfer_cnt}, 32'd32);

        // Random traffic, 200 words
        base = beats;
        pushed = 0;
        for (int cyc = 0; cyc < 3000 && (beats - base) < 200; cyc++) begin
            if (pushed < 200 && fifo_q.size() < 16 && $urandom_range(0, 3) != 0) begin
                fifo_q.push_back(8'($urandom));
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("t4_xfer_cnt", {16'd0, xfer_cnt}, 32'd232);

        // Flush with two buffered words and 0x13 in flight
        for (int i = 16; i < 32; i++) fifo_q.push_back(8'(i));
        m_ready = 1'b1;
        beat_seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !beat_seen; cyc++) cycle();
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 20 && !(exp_q.size() == 3 && edges < exp_q[2].ready_at); cyc++)
            cycle();
        saw13 = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t5_valid_after_flush", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b1;
        beat_seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !beat_seen; cyc++) cycle();
        chk("t5_first_after_flush", {24'd0, last_beat}, 32'h14);
        repeat (20) cycle();
        chk("t5_no_0x13", {31'd0, saw13}, 32'd0);
        chk("t5_xfer_cnt", {16'd0, xfer_cnt}, 32'd245);

        // Mid-stream reset after five beats
        for (int i = 32; i < 48; i++) fifo_q.push_back(8'(i));
        base = beats;
        for (int cyc = 0; cyc < 30 && (beats - base) < 5; cyc++) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t6_valid_after_rst", {31'd0, m_valid}, 32'd0);
        chk("t6_cnt_after_rst", {16'd0, xfer_cnt}, 32'd0);

        // 17 beats wrap the 4-bit counter to 1
        pushed = 0;
        for (int cyc = 0; cyc < 100 && beats < 17; cyc++) begin
            if (pushed < 17 && fifo_q.size() < 16) begin
                fifo_q.push_back(8'($urandom));
                pushed++;
            end
            cycle();
        end
        chk("t6_xfer_cnt17", {16'd0, xfer_cnt}, 32'd17);
        chk("t6_xfer_cnt4_wrap", {28'd0, xfer_cnt4}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
